// File: rtl/snax_alu_job_ctrl.sv
// Job sequencer for one SNAX ALU PE: accepts (op, length) jobs, gates PE input, counts output beats, pulses done.
// Optional busy-cycle counter built only when SNAX_ALU_JOB_CTRL_PERF_EN is defined.
module snax_alu_job_ctrl #(
    parameter int unsigned CntWidth = 16
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                cfg_valid_i,
    output logic                cfg_ready_o,
    input  logic [CntWidth-1:0] cfg_len_i,
    input  logic [1:0]          cfg_op_i,
    input  logic                abort_i,
    output logic [1:0]          pe_alu_config_o,
    output logic                pe_acc_ready_o,
    input  logic                pe_c_valid_i,
    input  logic                pe_c_ready_i,
    output logic                busy_o,
    output logic                done_o,
    output logic [CntWidth-1:0] beat_cnt_o,
    output logic [31:0]         perf_cycles_o
);

    localparam int unsigned PerfWidth = 32;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_e;

    state_e              state_q;
    logic [CntWidth-1:0] len_q;

    logic beat_c;
    logic accept_c;
    logic last_beat_c;

    assign beat_c      = pe_c_valid_i && pe_c_ready_i;
    assign accept_c    = (state_q == IDLE) && cfg_valid_i;
    assign last_beat_c = beat_c && (beat_cnt_o == len_q - CntWidth'(1));

    // Sequencer; every output is a register updated alongside the state transition.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q         <= IDLE;
            len_q           <= '0;
            beat_cnt_o      <= '0;
            pe_alu_config_o <= '0;
            cfg_ready_o     <= 1'b1;
            pe_acc_ready_o  <= 1'b0;
            busy_o          <= 1'b0;
            done_o          <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (cfg_valid_i) begin
                        pe_alu_config_o <= cfg_op_i;
                        len_q           <= cfg_len_i;
                        beat_cnt_o      <= '0;
                        cfg_ready_o     <= 1'b0;
                        if (cfg_len_i != '0) begin
                            state_q        <= BUSY;
                            pe_acc_ready_o <= 1'b1;
                            busy_o         <= 1'b1;
                        end else begin
                            state_q <= DONE;
                            done_o  <= 1'b1;
                        end
                    end
                end
                BUSY: begin
                    if (beat_c) begin
                        beat_cnt_o <= beat_cnt_o + CntWidth'(1);
                    end
                    // Abort wins over completion: no done pulse for a cancelled job.
                    if (abort_i) begin
                        state_q        <= IDLE;
                        cfg_ready_o    <= 1'b1;
                        pe_acc_ready_o <= 1'b0;
                        busy_o         <= 1'b0;
                    end else if (last_beat_c) begin
                        state_q        <= DONE;
                        pe_acc_ready_o <= 1'b0;
                        busy_o         <= 1'b0;
                        done_o         <= 1'b1;
                    end
                end
                DONE: begin
                    state_q     <= IDLE;
                    done_o      <= 1'b0;
                    cfg_ready_o <= 1'b1;
                end
                default: begin
                    state_q        <= IDLE;
                    cfg_ready_o    <= 1'b1;
                    pe_acc_ready_o <= 1'b0;
                    busy_o         <= 1'b0;
                    done_o         <= 1'b0;
                end
            endcase
        end
    end

`ifdef SNAX_ALU_JOB_CTRL_PERF_EN
    localparam logic [PerfWidth-1:0] PerfMax = '1;

    // Busy-cycle counter: cleared on accept, saturating, held after the job.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            perf_cycles_o <= '0;
        end else if (accept_c) begin
            perf_cycles_o <= '0;
        end else if ((state_q == BUSY) && (perf_cycles_o != PerfMax)) begin
            perf_cycles_o <= perf_cycles_o + PerfWidth'(1);
        end
    end
`else
    logic unused_accept_c;
    assign unused_accept_c = accept_c;
    assign perf_cycles_o   = PerfWidth'(0);
`endif

endmodule

// File: tb/tb_snax_alu_job_ctrl.sv
// Scoreboard bench for snax_alu_job_ctrl: stimulus pushes expected job results, a negedge monitor checks each done pulse.
module tb_snax_alu_job_ctrl;

    localparam int unsigned CW = 16;

    logic          clk = 1'b0;
    logic          rst_i;
    logic          cfg_valid_i;
    logic          cfg_ready_o;
    logic [CW-1:0] cfg_len_i;
    logic [1:0]    cfg_op_i;
    logic          abort_i;
    logic [1:0]    pe_alu_config_o;
    logic          pe_acc_ready_o;
    logic          pe_c_valid_i;
    logic          pe_c_ready_i;
    logic          busy_o;
    logic          done_o;
    logic [CW-1:0] beat_cnt_o;
    logic [31:0]   perf_cycles_o;

    always #5 clk = ~clk;

    snax_alu_job_ctrl #(.CntWidth(CW)) dut (
        .clk_i          (clk),
        .rst_i          (rst_i),
        .cfg_valid_i    (cfg_valid_i),
        .cfg_ready_o    (cfg_ready_o),
        .cfg_len_i      (cfg_len_i),
        .cfg_op_i       (cfg_op_i),
        .abort_i        (abort_i),
        .pe_alu_config_o(pe_alu_config_o),
        .pe_acc_ready_o (pe_acc_ready_o),
        .pe_c_valid_i   (pe_c_valid_i),
        .pe_c_ready_i   (pe_c_ready_i),
        .busy_o         (busy_o),
        .done_o         (done_o),
        .beat_cnt_o     (beat_cnt_o),
        .perf_cycles_o  (perf_cycles_o)
    );

    typedef struct {
        logic [CW-1:0] beats;
        logic [1:0]    op;
        int            acc;
        logic [31:0]   perf;
    } exp_t;

    exp_t sb[$];
    int   n_cmp = 0;
    int   n_err = 0;

    function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endfunction

    function automatic logic [31:0] perf_exp(input int cycles);
`ifdef SNAX_ALU_JOB_CTRL_PERF_EN
        return 32'(cycles);
`else
        return (cycles == 0) ? 32'd0 : 32'd0;
`endif
    endfunction

    // Monitor: checks op stability while busy, one-cycle done, and each done against the scoreboard.
    logic [1:0] mon_op = 2'd0;
    int         acc_cnt = 0;
    logic       prev_done = 1'b0;

    always @(negedge clk) begin
        exp_t e;
        if (pe_acc_ready_o === 1'b1) acc_cnt++;
        if (busy_o === 1'b1) chk("op_stable", 64'(pe_alu_config_o), 64'(mon_op));
        if (prev_done) chk("done_one_cycle", 64'(done_o), 64'd0);
        if (done_o === 1'b1) begin
            if (sb.size() == 0) begin
                n_cmp++;
                n_err++;
                $display("FAIL unexpected_done: got done_o=1 expected no pending job (t=%0t)", $time);
            end else begin
                e = sb.pop_front();
                chk("done_beat_cnt", 64'(beat_cnt_o), 64'(e.beats));
                chk("done_op", 64'(pe_alu_config_o), 64'(e.op));
                chk("done_acc_cycles", 64'(acc_cnt), 64'(e.acc));
                chk("done_perf", 64'(perf_cycles_o), 64'(e.perf));
            end
        end
        prev_done = (done_o === 1'b1);
        if (cfg_valid_i && cfg_ready_o === 1'b1 && !rst_i) begin
            mon_op  = cfg_op_i;
            acc_cnt = 0;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One job: stall window on consumer ready, optional abort at cycle abort_k (with a beat in it).
    task automatic run_job(input logic [1:0] op, input logic [CW-1:0] len,
                           input int stall_start, input int stall_len, input int abort_k);
        int n;
        logic [CW-1:0] exp_cnt;
        n = int'(len) + stall_len;
        chk("idle_ready", 64'(cfg_ready_o), 64'd1);
        if (abort_k < 0) sb.push_back('{len, op, n, perf_exp(n)});
        cfg_valid_i = 1'b1;
        cfg_op_i    = op;
        cfg_len_i   = len;
        tick();
        cfg_valid_i = 1'b0;
        cfg_op_i    = ~op;
        cfg_len_i   = '1;
        chk("acc_latency", 64'(pe_acc_ready_o), 64'(len != '0));
        chk("done_latency_len0", 64'(done_o), 64'(len == '0));
        exp_cnt = len;
        for (int k = 0; k < n; k++) begin
            pe_c_valid_i = 1'b1;
            pe_c_ready_i = !(k >= stall_start && k < stall_start + stall_len);
            abort_i      = (k == abort_k);
            tick();
            if (k == abort_k) begin
                exp_cnt = CW'(k + 1);
                break;
            end
        end
        abort_i = 1'b0;
        if (abort_k >= 0) begin
            chk("abort_busy", 64'(busy_o), 64'd0);
            chk("abort_acc", 64'(pe_acc_ready_o), 64'd0);
            chk("abort_ready", 64'(cfg_ready_o), 64'd1);
            chk("abort_done", 64'(done_o), 64'd0);
            chk("abort_perf", 64'(perf_cycles_o), 64'(perf_exp(abort_k + 1)));
        end
        // Beats outside BUSY must not count.
        pe_c_valid_i = 1'b1;
        pe_c_ready_i = 1'b1;
        tick();
        tick();
        chk("beat_hold", 64'(beat_cnt_o), 64'(exp_cnt));
        pe_c_valid_i = 1'b0;
        pe_c_ready_i = 1'b0;
        tick();
    endtask

    initial begin
        rst_i        = 1'b1;
        cfg_valid_i  = 1'b0;
        cfg_len_i    = '0;
        cfg_op_i     = 2'd0;
        abort_i      = 1'b0;
        pe_c_valid_i = 1'b0;
        pe_c_ready_i = 1'b0;
        tick();
        tick();
        chk("rst_cfg_ready", 64'(cfg_ready_o), 64'd1);
        chk("rst_busy", 64'(busy_o), 64'd0);
        chk("rst_acc", 64'(pe_acc_ready_o), 64'd0);
        chk("rst_done", 64'(done_o), 64'd0);
        chk("rst_op", 64'(pe_alu_config_o), 64'd0);
        chk("rst_beat_cnt", 64'(beat_cnt_o), 64'd0);
        chk("rst_perf", 64'(perf_cycles_o), 64'd0);
        rst_i = 1'b0;
        tick();

        run_job(2'd0, CW'(4), 0, 0, -1);   // basic add job
        run_job(2'd2, CW'(3), 1, 2, -1);   // mul with consumer stall
        run_job(2'd1, CW'(0), 0, 0, -1);   // zero-length job
        run_job(2'd3, CW'(8), 0, 0, 2);    // abort on third beat
        run_job(2'd3, CW'(1), 0, 0, -1);   // accepted after abort, len=1

        // Reset in the cycle of beat 2 of a 5-beat job.
        cfg_valid_i = 1'b1;
        cfg_op_i    = 2'd3;
        cfg_len_i   = CW'(5);
        tick();
        cfg_valid_i  = 1'b0;
        pe_c_valid_i = 1'b1;
        pe_c_ready_i = 1'b1;
        tick();
        rst_i = 1'b1;
        tick();
        rst_i = 1'b0;
        chk("midrst_cfg_ready", 64'(cfg_ready_o), 64'd1);
        chk("midrst_busy", 64'(busy_o), 64'd0);
        chk("midrst_acc", 64'(pe_acc_ready_o), 64'd0);
        chk("midrst_done", 64'(done_o), 64'd0);
        chk("midrst_op", 64'(pe_alu_config_o), 64'd0);
        chk("midrst_beat_cnt", 64'(beat_cnt_o), 64'd0);
        chk("midrst_perf", 64'(perf_cycles_o), 64'd0);
        pe_c_valid_i = 1'b0;
        pe_c_ready_i = 1'b0;
        repeat (4) tick();

        // cfg_valid held through BUSY/DONE; descriptor changes mid-job take effect only on the next accept.
        sb.push_back('{CW'(2), 2'd1, 2, perf_exp(2)});
        sb.push_back('{CW'(1), 2'd3, 1, perf_exp(1)});
        cfg_valid_i  = 1'b1;
        cfg_op_i     = 2'd1;
        cfg_len_i    = CW'(2);
        pe_c_valid_i = 1'b1;
        pe_c_ready_i = 1'b1;
        tick();
        cfg_op_i  = 2'd3;
        cfg_len_i = CW'(1);
        chk("hold_ready_busy", 64'(cfg_ready_o), 64'd0);
        tick();
        tick();
        chk("hold_ready_done", 64'(cfg_ready_o), 64'd0);
        chk("hold_done", 64'(done_o), 64'd1);
        tick();
        chk("hold_ready_idle", 64'(cfg_ready_o), 64'd1);
        tick();
        cfg_valid_i = 1'b0;
        chk("hold_second_busy", 64'(busy_o), 64'd1);
        repeat (3) tick();
        pe_c_valid_i = 1'b0;
        pe_c_ready_i = 1'b0;
        repeat (3) tick();

        chk("sb_drained", 64'(sb.size()), 64'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
